mem_responder: RTL and testbench

- Memory-side responder for the multi-cycle CPU's two bus channels.
- Instruction channel: PC request, then Instruction response.
- Data channel: Address/MemRead/MemWrite request, then Read_data response.
- Serves both channels from one word-organised RAM with programmable response latency. Used as the simulation and FPGA memory model behind custom_cpu.

---
 rtl/mem_responder.sv | 187 ++++++++++++++++++
 tb/tb_mem_responder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Two-channel (instruction + data) memory responder with programmable response latency.
// Define MEM_RAND_LAT_EN to add 0..3 LFSR-driven extra latency cycles per request.
module mem_responder #(
  parameter int          ADDR_W    = 12,
  parameter int          LATENCY   = 2,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC,
  input  logic        Inst_Req_Valid,
  output logic        Inst_Req_Ready,
  output logic [31:0] Instruction,
  output logic        Inst_Valid,
  input  logic        Inst_Ready,
  input  logic [31:0] Address,
  input  logic        MemWrite,
  input  logic [31:0] Write_data,
  input  logic [3:0]  Write_strb,
  input  logic        MemRead,
  output logic        Mem_Req_Ready,
  output logic [31:0] Read_data,
  output logic        Read_data_Valid,
  input  logic        Read_data_Ready
);

  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [4:0] BASE_LAT = 5'(LATENCY);

  typedef enum logic [1:0] {I_IDLE, I_WAIT, I_RESP} inst_state_t;
  typedef enum logic [1:0] {D_IDLE, D_WAIT, D_RESP, D_WBUSY} data_state_t;

  logic [31:0] mem [0:DEPTH-1];

  inst_state_t       inst_state_reg;
  data_state_t       data_state_reg;
  logic [4:0]        inst_cnt_reg, data_cnt_reg;
  logic [ADDR_W-1:0] inst_idx_reg, data_idx_reg;
  logic [4:0]        inst_lat, data_lat;

  logic [ADDR_W-1:0] pc_idx, addr_idx, inst_rd_idx, data_rd_idx;
  logic              write_en;

  assign pc_idx   = PC[ADDR_W+1:2];
  assign addr_idx = Address[ADDR_W+1:2];

  // In IDLE the read port looks at the live request so zero-latency captures work.
  assign inst_rd_idx = (inst_state_reg == I_IDLE) ? pc_idx : inst_idx_reg;
  assign data_rd_idx = (data_state_reg == D_IDLE) ? addr_idx : data_idx_reg;

`ifdef MEM_RAND_LAT_EN
  logic [15:0] lfsr_reg;
  logic        lfsr_fb;

  assign lfsr_fb = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_reg <= LFSR_SEED;
    end else begin
      lfsr_reg <= {lfsr_reg[14:0], lfsr_fb};
    end
  end

  assign inst_lat = BASE_LAT + {3'b000, lfsr_reg[1:0]};
  assign data_lat = BASE_LAT + {3'b000, lfsr_reg[3:2]};
`else
  assign inst_lat = BASE_LAT;
  assign data_lat = BASE_LAT;
`endif

  // Ready is gated by rst so it reads 0 for the whole reset cycle, not one cycle late.
  assign Inst_Req_Ready = (inst_state_reg == I_IDLE) && !rst;
  assign Mem_Req_Ready  = (data_state_reg == D_IDLE) && !rst;
  assign write_en       = Mem_Req_Ready && MemWrite;

  always_ff @(posedge clk) begin
    if (write_en) begin
      for (int b = 0; b < 4; b++) begin
        if (Write_strb[b]) begin
          mem[addr_idx][8*b +: 8] <= Write_data[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_state_reg <= I_IDLE;
      inst_cnt_reg   <= '0;
      inst_idx_reg   <= '0;
      Instruction    <= '0;
      Inst_Valid     <= 1'b0;
    end else begin
      case (inst_state_reg)
        I_IDLE: begin
          if (Inst_Req_Valid) begin
            inst_idx_reg <= pc_idx;
            if (inst_lat == 5'd0) begin
              Instruction    <= mem[inst_rd_idx];
              Inst_Valid     <= 1'b1;
              inst_state_reg <= I_RESP;
            end else begin
              inst_cnt_reg   <= inst_lat;
              inst_state_reg <= I_WAIT;
            end
          end
        end
        I_WAIT: begin
          if (inst_cnt_reg == 5'd1) begin
            Instruction    <= mem[inst_rd_idx];
            Inst_Valid     <= 1'b1;
            inst_state_reg <= I_RESP;
          end else begin
            inst_cnt_reg <= inst_cnt_reg - 5'd1;
          end
        end
        I_RESP: begin
          if (Inst_Ready) begin
            Inst_Valid     <= 1'b0;
            inst_state_reg <= I_IDLE;
          end
        end
        default: inst_state_reg <= I_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_state_reg  <= D_IDLE;
      data_cnt_reg    <= '0;
      data_idx_reg    <= '0;
      Read_data       <= '0;
      Read_data_Valid <= 1'b0;
    end else begin
      case (data_state_reg)
        D_IDLE: begin
          // A store wins over a simultaneous load; the load is dropped.
          if (MemWrite) begin
            if (data_lat != 5'd0) begin
              data_cnt_reg   <= data_lat;
              data_state_reg <= D_WBUSY;
            end
          end else if (MemRead) begin
            data_idx_reg <= addr_idx;
            if (data_lat == 5'd0) begin
              Read_data       <= mem[data_rd_idx];
              Read_data_Valid <= 1'b1;
              data_state_reg  <= D_RESP;
            end else begin
              data_cnt_reg   <= data_lat;
              data_state_reg <= D_WAIT;
            end
          end
        end
        D_WAIT: begin
          if (data_cnt_reg == 5'd1) begin
            Read_data       <= mem[data_rd_idx];
            Read_data_Valid <= 1'b1;
            data_state_reg  <= D_RESP;
          end else begin
            data_cnt_reg <= data_cnt_reg - 5'd1;
          end
        end
        D_RESP: begin
          if (Read_data_Ready) begin
            Read_data_Valid <= 1'b0;
            data_state_reg  <= D_IDLE;
          end
        end
        D_WBUSY: begin
          if (data_cnt_reg == 5'd1) begin
            data_state_reg <= D_IDLE;
          end else begin
            data_cnt_reg <= data_cnt_reg - 5'd1;
          end
        end
        default: data_state_reg <= D_IDLE;
      endcase
    end
  end

  logic unused_addr_bits;
  assign unused_addr_bits = ^{PC[31:ADDR_W+2], PC[1:0], Address[31:ADDR_W+2], Address[1:0]};

endmodule

// File: tb/tb_mem_responder.sv
// Directed testbench for mem_responder: one LATENCY=2 instance and one LATENCY=0 instance
// share the request inputs; each check targets the instance whose timing it describes.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PC;
  logic        Inst_Req_Valid;
  logic        Inst_Ready;
  logic [31:0] Address;
  logic        MemWrite;
  logic [31:0] Write_data;
  logic [3:0]  Write_strb;
  logic        MemRead;
  logic        Read_data_Ready;

  logic        Inst_Req_Ready, Inst_Valid, Mem_Req_Ready, Read_data_Valid;
  logic [31:0] Instruction, Read_data;
  logic        z_inst_req_ready, z_inst_valid, z_mem_req_ready, z_read_data_valid;
  logic [31:0] z_instruction, z_read_data;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_W(12), .LATENCY(2)) u_dut (
    .clk(clk), .rst(rst),
    .PC(PC), .Inst_Req_Valid(Inst_Req_Valid), .Inst_Req_Ready(Inst_Req_Ready),
    .Instruction(Instruction), .Inst_Valid(Inst_Valid), .Inst_Ready(Inst_Ready),
    .Address(Address), .MemWrite(MemWrite), .Write_data(Write_data), .Write_strb(Write_strb),
    .MemRead(MemRead), .Mem_Req_Ready(Mem_Req_Ready), .Read_data(Read_data),
    .Read_data_Valid(Read_data_Valid), .Read_data_Ready(Read_data_Ready)
  );

  mem_responder #(.ADDR_W(12), .LATENCY(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .PC(PC), .Inst_Req_Valid(Inst_Req_Valid), .Inst_Req_Ready(z_inst_req_ready),
    .Instruction(z_instruction), .Inst_Valid(z_inst_valid), .Inst_Ready(Inst_Ready),
    .Address(Address), .MemWrite(MemWrite), .Write_data(Write_data), .Write_strb(Write_strb),
    .MemRead(MemRead), .Mem_Req_Ready(z_mem_req_ready), .Read_data(z_read_data),
    .Read_data_Valid(z_read_data_valid), .Read_data_Ready(Read_data_Ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the data channel idle; returns at the negedge where it is idle again.
  task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    check("store_ready", Mem_Req_Ready, 1);
    Address = addr; Write_data = data; Write_strb = strb; MemWrite = 1'b1;
    @(negedge clk);
    MemWrite = 1'b0;
    check("wbusy_1", Mem_Req_Ready, 0);
    @(negedge clk);
    check("wbusy_2", Mem_Req_Ready, 0);
    @(negedge clk);
    check("wbusy_end", Mem_Req_Ready, 1);
    $display("[TB] store addr=%h data=%h strb=%b", addr, data, strb);
  endtask

  task automatic load(input logic [31:0] addr, input logic [31:0] exp);
    check("load_ready", Mem_Req_Ready, 1);
    Address = addr; MemRead = 1'b1;
    @(negedge clk);
    MemRead = 1'b0;
    check("load_wait_1", Read_data_Valid, 0);
    @(negedge clk);
    check("load_wait_2", Read_data_Valid, 0);
    @(negedge clk);
    check("load_valid", Read_data_Valid, 1);
    check("load_data", Read_data, exp);
    @(negedge clk);
    check("load_drop", Read_data_Valid, 0);
    check("load_idle", Mem_Req_Ready, 1);
    $display("[TB] load addr=%h data=%h", addr, Read_data);
  endtask

  task automatic fetch(input logic [31:0] addr, input logic [31:0] exp);
    check("fetch_ready", Inst_Req_Ready, 1);
    PC = addr; Inst_Req_Valid = 1'b1;
    @(negedge clk);
    Inst_Req_Valid = 1'b0;
    check("fetch_busy", Inst_Req_Ready, 0);
    check("fetch_wait_1", Inst_Valid, 0);
    @(negedge clk);
    check("fetch_wait_2", Inst_Valid, 0);
    @(negedge clk);
    check("fetch_valid", Inst_Valid, 1);
    check("fetch_data", Instruction, exp);
    @(negedge clk);
    check("fetch_drop", Inst_Valid, 0);
    check("fetch_idle", Inst_Req_Ready, 1);
    $display("[TB] fetch pc=%h inst=%h", addr, exp);
  endtask

  initial begin
    logic saw;
    rst = 1'b1; PC = '0; Inst_Req_Valid = 1'b0; Address = '0; MemWrite = 1'b0;
    Write_data = '0; Write_strb = '0; MemRead = 1'b0;
    Inst_Ready = 1'b1; Read_data_Ready = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_inst_req_ready", Inst_Req_Ready, 0);
    check("rst_mem_req_ready", Mem_Req_Ready, 0);
    check("rst_inst_valid", Inst_Valid, 0);
    check("rst_rd_valid", Read_data_Valid, 0);
    check("rst_instruction", Instruction, 0);
    check("rst_read_data", Read_data, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_inst_ready", Inst_Req_Ready, 1);
    check("post_rst_mem_ready", Mem_Req_Ready, 1);

    // Preload through the store path.
    store(32'h0000000C, 32'h24080005, 4'hF);
    store(32'h00000000, 32'h11111111, 4'hF);
    store(32'h00000004, 32'h22222222, 4'hF);
    store(32'h00000100, 32'h00000000, 4'hF);

    fetch(32'h0000000C, 32'h24080005);

    store(32'h00000100, 32'hAABBCCDD, 4'b0101);
    load(32'h00000100, 32'h00BB00DD);

    // Backpressure: hold the load response for 5 cycles.
    Read_data_Ready = 1'b0;
    Address = 32'h0; MemRead = 1'b1;
    @(negedge clk);
    MemRead = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", Read_data_Valid, 1);
      check("bp_data", Read_data, 32'h11111111);
      check("bp_busy", Mem_Req_Ready, 0);
      @(negedge clk);
    end
    Read_data_Ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", Read_data_Valid, 0);
    check("bp_release_ready", Mem_Req_Ready, 1);
    $display("[TB] backpressured load addr=00000000 released");

    // Concurrent fetch + load on the zero-latency instance.
    check("cc_inst_ready", z_inst_req_ready, 1);
    check("cc_mem_ready", z_mem_req_ready, 1);
    PC = 32'h0; Inst_Req_Valid = 1'b1; Address = 32'h4; MemRead = 1'b1;
    @(negedge clk);
    Inst_Req_Valid = 1'b0; MemRead = 1'b0;
    check("cc_inst_valid", z_inst_valid, 1);
    check("cc_instruction", z_instruction, 32'h11111111);
    check("cc_rd_valid", z_read_data_valid, 1);
    check("cc_read_data", z_read_data, 32'h22222222);
    repeat (3) @(negedge clk);
    check("cc_l2_inst", Instruction, 32'h11111111);
    check("cc_l2_data", Read_data, 32'h22222222);
    $display("[TB] concurrent fetch pc=00000000 and load addr=00000004");

    // Reset during instruction WAIT.
    check("rm_ready", Inst_Req_Ready, 1);
    PC = 32'hC; Inst_Req_Valid = 1'b1;
    @(negedge clk);
    Inst_Req_Valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rm_ready_in_rst", Inst_Req_Ready, 0);
    check("rm_mem_ready_in_rst", Mem_Req_Ready, 0);
    rst = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) check("rm_ready_after", Inst_Req_Ready, 1);
      saw = saw | Inst_Valid;
    end
    check("rm_no_valid", {31'b0, saw}, 0);
    fetch(32'h0000000C, 32'h24080005);
    $display("[TB] reset mid-fetch recovered");

    // Address wrap.
    store(32'h00004000, 32'hCAFEF00D, 4'hF);
    load(32'h00000000, 32'hCAFEF00D);

    // Store and load together: only the store happens.
    Address = 32'h8; Write_data = 32'h5A5A5A5A; Write_strb = 4'hF; MemWrite = 1'b1; MemRead = 1'b1;
    @(negedge clk);
    MemWrite = 1'b0; MemRead = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 5; i++) begin
      saw = saw | Read_data_Valid;
      @(negedge clk);
    end
    check("prio_no_rd_valid", {31'b0, saw}, 0);
    $display("[TB] store+load together addr=00000008");
    load(32'h00000008, 32'h5A5A5A5A);

    // Zero strobe: WBUSY timing but no update.
    store(32'h00000008, 32'hFFFFFFFF, 4'b0000);
    load(32'h00000008, 32'h5A5A5A5A);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
